addsub_accumulator: RTL

- Sequential accumulator stage wrapped around the combinational N-bit adder-subtractor.
- Accepts operation commands over a valid/ready handshake and drives the adder-subtractor operands (A = accumulator, B = command operand, Op).
- Captures S/Cout back into the accumulator and computes status flags.
- Presents each result over a valid/ready output handshake; it is both the producer and the consumer of the adder-subtractor.

---
 rtl/addsub_accumulator_if.sv | 31 +++
 rtl/addsub_accumulator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/addsub_accumulator_if.sv
// Command/result bundle for addsub_accumulator.
//   in_valid/in_ready/in_cmd/in_data : command handshake (master -> slave)
//   out_valid/out_ready              : result handshake (slave -> master)
//   acc, flag_c/z/n/v                : registered result and status flags
// The accumulator itself connects through the slave modport; the command
// source and result sink connect through the master modport.
interface addsub_accumulator_if #(
    parameter int unsigned N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_cmd;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc;
    logic         flag_c;
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;

    modport slave (
        input  in_valid, in_cmd, in_data, out_ready,
        output in_ready, out_valid, acc, flag_c, flag_z, flag_n, flag_v
    );

    modport master (
        output in_valid, in_cmd, in_data, out_ready,
        input  in_ready, out_valid, acc, flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/addsub_accumulator.sv
// Sequential accumulator stage around an external combinational N-bit
// adder-subtractor. Commands (ADD/SUB/LOAD/CLEAR) are accepted over a
// valid/ready handshake, executed in one cycle, and the result is presented
// over a valid/ready output handshake.
// Ports:
//   clk, rst_n     : clock (rising edge) and synchronous active-low reset
//   bus (slave)    : command/result handshakes, acc and status flags
//   as_a/as_b/as_op: operands and operation driven to the adder-subtractor
//   as_s/as_cout   : sum/difference and carry back from the adder-subtractor
module addsub_accumulator #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_accumulator_if.slave  bus,
    output logic [N-1:0]         as_a,
    output logic [N-1:0]         as_b,
    output logic                 as_op,
    input  logic [N-1:0]         as_s,
    input  logic                 as_cout
);

    localparam logic [1:0] CmdAdd   = 2'b00;
    localparam logic [1:0] CmdSub   = 2'b01;
    localparam logic [1:0] CmdLoad  = 2'b10;
    localparam logic [1:0] CmdClear = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cmd_q;
    logic [N-1:0] opnd_q;
    logic [N-1:0] acc_q, acc_d;
    logic         flag_c_q, flag_c_d;
    logic         flag_v_q, flag_v_d;
    logic         flag_z_q, flag_n_q;
    logic         out_valid_q;
    logic         accept;

    assign as_a  = acc_q;
    assign as_b  = opnd_q;
    assign as_op = (cmd_q == CmdSub);

    assign bus.acc       = acc_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_v    = flag_v_q;
    assign bus.out_valid = out_valid_q;

    // Handshake and next-state.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                // Result consumption and a new command may share one cycle.
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result of the command held in cmd_q/opnd_q; only committed in StExec.
    always_comb begin
        acc_d    = acc_q;
        flag_c_d = 1'b0;
        flag_v_d = 1'b0;
        unique case (cmd_q)
            CmdAdd: begin
                acc_d    = as_s;
                flag_c_d = as_cout;
                flag_v_d = (acc_q[N-1] == opnd_q[N-1]) && (as_s[N-1] != acc_q[N-1]);
            end
            CmdSub: begin
                acc_d    = as_s;
                flag_c_d = as_cout;
                flag_v_d = (acc_q[N-1] != opnd_q[N-1]) && (as_s[N-1] != acc_q[N-1]);
            end
            CmdLoad:  acc_d = opnd_q;
            CmdClear: acc_d = '0;
            default:  acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b1;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == StResp);
            if (accept) begin
                cmd_q  <= bus.in_cmd;
                opnd_q <= bus.in_data;
            end
            if (state_q == StExec) begin
                acc_q    <= acc_d;
                flag_c_q <= flag_c_d;
                flag_v_q <= flag_v_d;
                flag_z_q <= (acc_d == '0);
                flag_n_q <= acc_d[N-1];
            end
        end
    end

endmodule
